// File: rtl/ex_mem_pkg.sv
// Shared types for the execute/memory pipeline boundary: buffered entry layout,
// boundary FSM states and the "no trap" cause value.
package ex_mem_pkg;

    localparam int XLEN = 64;
    localparam logic [4:0] CAUSE_NONE = 5'd0;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        WFI
    } ex_mem_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] tval;
        logic [4:0]      cause;
        logic            load;
        logic            store;
    } ex_entry_t;

endpackage

// File: rtl/skid_buf2.sv
// Generic two-entry FIFO skid buffer with a registered input ready.
// The owner gates acceptance for the next cycle through in_allow.
module skid_buf2 #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    input  logic in_allow,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data,
    output logic empty
);

    T     head_q, head_d;
    T     skid_q, skid_d;
    logic head_valid_q, head_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;
    logic push, pop;

    assign push = in_valid && in_ready_q && !flush;
    assign pop  = head_valid_q && out_ready;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (pop) begin
                head_valid_d = skid_valid_q;
                head_d       = skid_valid_q ? skid_q : head_q;
                skid_valid_d = 1'b0;
            end
            // Push lands in the head whenever the head is (or becomes) free.
            if (push) begin
                if (!head_valid_d) begin
                    head_d       = in_data;
                    head_valid_d = 1'b1;
                end else begin
                    skid_d       = in_data;
                    skid_valid_d = 1'b1;
                end
            end
        end
        in_ready_d = !skid_valid_d && in_allow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = head_valid_q;
    assign out_data  = head_q;
    assign empty     = !head_valid_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: two-entry skid buffer plus the RUN/DRAIN/WFI FSM
// that issues one-cycle fetch redirects for traps, taken branches and WFI wake-up.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_data2,
    input  logic [XLEN-1:0] ex_tval,
    input  logic [4:0]      ex_rd,
    input  logic            ex_load,
    input  logic            ex_store,
    input  logic            ex_wfi,
    input  logic [4:0]      ex_cause,
    input  logic            ex_bj_en,
    input  logic [XLEN-1:0] ex_bj_pc,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_pc,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_data2,
    output logic [XLEN-1:0] mem_tval,
    output logic [4:0]      mem_rd,
    output logic            mem_load,
    output logic            mem_store,
    output logic [4:0]      mem_cause,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            trap_done,
    input  logic            irq_pending,
    input  logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] PC_STEP = 4;

    ex_mem_state_e   state_q, state_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] wfi_pc_q, wfi_pc_d;
    ex_entry_t       ex_entry, mem_entry;
    logic            accept, buf_empty, wake;

    always_comb begin
        ex_entry        = '0;
        ex_entry.pc     = ex_pc;
        ex_entry.rd     = ex_rd;
        ex_entry.result = ex_result;
        ex_entry.data2  = ex_data2;
        ex_entry.tval   = ex_tval;
        ex_entry.cause  = ex_cause;
        ex_entry.load   = ex_load;
        ex_entry.store  = ex_store;
    end

    assign accept = ex_valid && ex_ready && !flush && (state_q == RUN);
    assign wake   = (state_q == WFI) && buf_empty && irq_pending;

    skid_buf2 #(.T(ex_entry_t)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (ex_valid),
        .in_allow  (state_d == RUN),
        .in_ready  (ex_ready),
        .in_data   (ex_entry),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .out_data  (mem_entry),
        .empty     (buf_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // trap_done is only honoured once already in DRAIN, never on the entry cycle.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) begin
                        if (ex_cause != CAUSE_NONE)  state_d = DRAIN;
                        else if (!ex_bj_en && ex_wfi) state_d = WFI;
                    end
                end
                DRAIN:   if (trap_done) state_d = RUN;
                WFI:     if (wake)      state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        wfi_pc_d         = wfi_pc_q;
        if (!flush) begin
            if (accept) begin
                if (ex_cause != CAUSE_NONE) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = trap_vec;
                end else if (ex_bj_en) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = ex_bj_pc;
                end else if (ex_wfi) begin
                    wfi_pc_d = ex_pc;
                end
            end else if (wake) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = wfi_pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_PC;
            wfi_pc_q         <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            wfi_pc_q         <= wfi_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mem_pc         = mem_entry.pc;
    assign mem_result     = mem_entry.result;
    assign mem_data2      = mem_entry.data2;
    assign mem_tval       = mem_entry.tval;
    assign mem_rd         = mem_entry.rd;
    assign mem_load       = mem_entry.load;
    assign mem_store      = mem_entry.store;
    assign mem_cause      = mem_entry.cause;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized + directed bench for ex_mem_stage against a queue-based model
// of the boundary (FIFO of entries, mode, last redirect).
module tb_ex_mem_stage;
    import ex_mem_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam int M_RUN = 0, M_DRAIN = 1, M_WFI = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid, ex_ready, ex_load, ex_store, ex_wfi, ex_bj_en;
    logic [63:0] ex_pc, ex_result, ex_data2, ex_tval, ex_bj_pc;
    logic [4:0]  ex_rd, ex_cause;
    logic        mem_valid, mem_ready, mem_load, mem_store;
    logic [63:0] mem_pc, mem_result, mem_data2, mem_tval;
    logic [4:0]  mem_rd, mem_cause;
    logic [63:0] trap_vec, redirect_pc;
    logic        trap_done, irq_pending, flush, redirect_valid;

    ex_mem_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_result(ex_result),
        .ex_data2(ex_data2), .ex_tval(ex_tval), .ex_rd(ex_rd), .ex_load(ex_load),
        .ex_store(ex_store), .ex_wfi(ex_wfi), .ex_cause(ex_cause), .ex_bj_en(ex_bj_en),
        .ex_bj_pc(ex_bj_pc), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc),
        .mem_result(mem_result), .mem_data2(mem_data2), .mem_tval(mem_tval), .mem_rd(mem_rd),
        .mem_load(mem_load), .mem_store(mem_store), .mem_cause(mem_cause),
        .trap_vec(trap_vec), .trap_done(trap_done), .irq_pending(irq_pending), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // reference model
    ex_entry_t   mq[$];
    int          mode = M_RUN;
    logic        m_rv = 1'b0;
    logic [63:0] m_rpc = RST_PC;
    logic [63:0] m_wfi_pc = '0;

    task automatic model_reset();
        mq.delete();
        mode = M_RUN; m_rv = 1'b0; m_rpc = RST_PC;
    endtask

    task automatic idle();
        ex_valid = 0; ex_pc = '0; ex_result = '0; ex_data2 = '0; ex_tval = '0; ex_rd = '0;
        ex_load = 0; ex_store = 0; ex_wfi = 0; ex_cause = '0; ex_bj_en = 0; ex_bj_pc = '0;
        mem_ready = 1; trap_vec = '0; trap_done = 0; irq_pending = 0; flush = 0;
    endtask

    task automatic instr(input logic [63:0] pc);
        ex_valid = 1; ex_pc = pc; ex_result = {$urandom, $urandom}; ex_data2 = {$urandom, $urandom};
        ex_tval = {$urandom, $urandom}; ex_rd = 5'($urandom); ex_load = 1'($urandom);
        ex_store = 1'($urandom); ex_wfi = 0; ex_cause = '0; ex_bj_en = 0; ex_bj_pc = '0;
    endtask

    // One clock: evaluate the model on the pre-edge inputs, then compare after the edge.
    task automatic step();
        ex_entry_t e;
        bit acc, pop, was_empty;
        e = '0;
        e.pc = ex_pc; e.rd = ex_rd; e.result = ex_result; e.data2 = ex_data2;
        e.tval = ex_tval; e.cause = ex_cause; e.load = ex_load; e.store = ex_store;
        acc = ex_valid && (mq.size() < 2) && (mode == M_RUN) && !flush;
        pop = (mq.size() > 0) && mem_ready;
        was_empty = (mq.size() == 0);
        @(posedge clk);
        #1;
        m_rv = 1'b0;
        if (flush) begin
            mq.delete();
            mode = M_RUN;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            if (mode == M_RUN && acc) begin
                if (e.cause != 0) begin m_rv = 1; m_rpc = trap_vec; mode = M_DRAIN; end
                else if (ex_bj_en) begin m_rv = 1; m_rpc = ex_bj_pc; end
                else if (ex_wfi) begin m_wfi_pc = ex_pc; mode = M_WFI; end
            end else if (mode == M_DRAIN && trap_done) begin
                mode = M_RUN;
            end else if (mode == M_WFI && was_empty && irq_pending) begin
                m_rv = 1; m_rpc = m_wfi_pc + 64'd4; mode = M_RUN;
            end
        end
        chk("mem_valid", mem_valid, mq.size() > 0);
        chk("ex_ready", ex_ready, (mq.size() < 2) && (mode == M_RUN));
        chk("redirect_valid", redirect_valid, m_rv);
        chk("redirect_pc", redirect_pc, m_rpc);
        if (mq.size() > 0) begin
            chk("mem_pc", mem_pc, mq[0].pc);
            chk("mem_result", mem_result, mq[0].result);
            chk("mem_data2", mem_data2, mq[0].data2);
            chk("mem_tval", mem_tval, mq[0].tval);
            chk("mem_rd_cause_ls", {mem_rd, mem_cause, mem_load, mem_store},
                {mq[0].rd, mq[0].cause, mq[0].load, mq[0].store});
        end
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    initial begin
        idle();
        #12;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_fields", mem_pc | mem_result | mem_data2 | mem_tval, 0);
        chk("rst_mem_ctl", {mem_rd, mem_cause, mem_load, mem_store}, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, RST_PC);
        #1 rst_n = 1;
        step();

        // streaming, 8 back-to-back
        for (int i = 0; i < 8; i++) begin instr(64'h1000 + 64'(4 * i)); step(); end
        drain();

        // backpressure: three offered while memory stalls
        mem_ready = 0;
        instr(64'h2000); step();
        instr(64'h2004); step();
        chk("bp_ready_low", ex_ready, 0);
        instr(64'h2008); step();
        mem_ready = 1; step(); step(); step();
        drain();

        // taken branch
        instr(64'h8000_0010); ex_bj_en = 1; ex_bj_pc = 64'h8000_0100; step();
        chk("br_redirect", {63'd0, redirect_valid}, 1);
        chk("br_target", redirect_pc, 64'h8000_0100);
        idle(); step();
        chk("br_pulse_end", redirect_valid, 0);
        drain();

        // trap, then trap_done coincident with a second trap acceptance
        instr(64'h8000_0030); ex_cause = 5'd2; trap_vec = 64'h8000_0400; step();
        chk("trap_target", redirect_pc, 64'h8000_0400);
        idle(); step(); step();
        trap_done = 1; step();
        chk("trap_release", ex_ready, 1);
        idle();
        instr(64'h8000_0040); ex_cause = 5'd3; trap_vec = 64'h8000_0800; trap_done = 1; step();
        idle(); step();
        chk("trap_done_same_cycle", ex_ready, 0);
        trap_done = 1; step();
        drain();

        // WFI with irq held while the buffer still holds work, then a wrapping wake-up
        mem_ready = 0;
        instr(64'h8000_0020); ex_wfi = 1; step();
        idle(); mem_ready = 0; irq_pending = 1; step();
        mem_ready = 1; step(); step();
        chk("wfi_wake_pc", redirect_pc, 64'h8000_0024);
        step();
        chk("wfi_back_to_run", ex_ready, 1);
        instr(64'hFFFF_FFFF_FFFF_FFFE); ex_wfi = 1; step();
        idle(); irq_pending = 1; step(); step();
        chk("wfi_wrap_pc", redirect_pc, 64'h2);
        drain();

        // flush with both entries full and a branch redirect just issued
        mem_ready = 0;
        instr(64'h3000); step();
        instr(64'h3004); ex_bj_en = 1; ex_bj_pc = 64'h3100; step();
        instr(64'h3008); mem_ready = 0; flush = 1; step();
        chk("flush_mem_valid", mem_valid, 0);
        chk("flush_no_redirect", redirect_valid, 0);
        // acceptance in the flush cycle is dropped
        instr(64'h3010); ex_bj_en = 1; ex_bj_pc = 64'h3200; flush = 1; step();
        chk("flush_acc_dropped", {mem_valid, redirect_valid}, 0);
        drain();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            instr({$urandom, $urandom});
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_cause    = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            ex_bj_en    = ($urandom_range(0, 5) == 0);
            ex_bj_pc    = {$urandom, $urandom};
            ex_wfi      = ($urandom_range(0, 11) == 0);
            trap_vec    = {$urandom, $urandom};
            mem_ready   = ($urandom_range(0, 3) != 0);
            trap_done   = ($urandom_range(0, 3) == 0);
            irq_pending = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 40) == 0);
            step();
        end

        // asynchronous reset mid-operation
        idle(); mem_ready = 0;
        instr(64'h4000); step();
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("amid_rst_mem_valid", mem_valid, 0);
        chk("amid_rst_redirect", {redirect_valid, redirect_pc}, {1'b0, RST_PC});
        #1 rst_n = 1;
        idle();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline boundary between the execute stage and the memory stage of the RV64 core. It holds executed instructions in a two-entry skid buffer with valid/ready handshakes on both sides. It issues a one-cycle fetch redirect for taken branches and jumps, traps and WFI wake-up, and it blocks new instructions while a trap drains or the core sleeps in WFI.

## Interface
- XLEN, 64, datapath and PC width
- RESET_PC, 64'h8000_0000, value of `redirect_pc` after reset
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  block can accept; registered, equals `~skid_valid && state==RUN`
- ex_pc, ex_result, ex_data2, ex_tval  in  XLEN each  instruction PC, ALU result, store data, trap value
- ex_rd  in  5  destination register
- ex_load, ex_store, ex_wfi  in  1 each  operation class
- ex_cause  in  5  trap cause; 0 = no trap
- ex_bj_en  in  1  branch or jump taken
- ex_bj_pc  in  XLEN  branch or jump target
- mem_valid  out  1  head entry valid
- mem_ready  in  1  memory stage consumes the head
- mem_pc, mem_result, mem_data2, mem_tval, mem_rd, mem_load, mem_store, mem_cause  out  head entry fields
- trap_vec  in  XLEN  trap handler address (from CSR mtvec)
- trap_done  in  1  commit has taken the trap; releases DRAIN
- irq_pending  in  1  wakes the core from WFI
- flush  in  1  synchronous kill from commit; highest priority
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  XLEN  redirect target

## Operation
- Accept: `ex_valid && ex_ready`. An accepted instruction goes to the head if the head is empty or the head leaves in the same cycle. Otherwise it goes to the skid entry.
- Pop: `mem_valid && mem_ready`. On a pop the skid entry moves to the head.
- Order is strictly FIFO. The buffer never overflows because `ex_ready` is low whenever the skid entry is full.
- Redirect sources are evaluated on acceptance. At most one redirect is issued per accepted instruction, and it is registered on the next cycle.
- Redirect priority, highest first:
  - cause≠0: `redirect_pc=trap_vec`, next state DRAIN. The instruction is still forwarded with its cause.
  - bj_en: `redirect_pc=ex_bj_pc`. The instruction is forwarded, so jal/jalr still write rd.
  - wfi: no redirect. The instruction is forwarded and the next state is WFI.
- FSM states are RUN, DRAIN and WFI.
  - RUN: normal operation.
  - DRAIN: `ex_ready=0`. Returns to RUN on `trap_done`.
  - WFI: `ex_ready=0`. Waits until the buffer is empty. When `irq_pending` is seen with the buffer empty, pulse a redirect to `wfi_pc+4` and return to RUN.
  - `wfi_pc` is latched when the WFI instruction is accepted.
- Flush: clears both entries and any pending redirect, and sets state to RUN in the same edge. An acceptance in the flush cycle is discarded.
- All arithmetic is modulo 2^XLEN. `wfi_pc+4` wraps silently.

## Timing
- Reset values:
  - mem_valid=0, all mem_* fields=0.
  - redirect_valid=0, redirect_pc=RESET_PC.
  - state=RUN, skid empty, ex_ready=1 on the first cycle after reset release.
- Latency from acceptance into an empty buffer to mem_valid is 1 cycle. Throughput is 1 instruction per cycle with mem_ready held high.
- mem_* fields are stable while `mem_valid && !mem_ready`.
- redirect_valid is high for exactly one cycle, the cycle after the triggering acceptance or wake-up.
- Simultaneous accept and pop with the skid entry empty: the new instruction replaces the head and ex_ready stays 1.
- `trap_done` in the same cycle as a DRAIN-causing acceptance: the block still enters DRAIN and waits for a later `trap_done`.
- `irq_pending` while the buffer is non-empty in WFI: ignored until the buffer is empty. The level is sampled each cycle.
- Reset mid-operation: all entries, state and pending redirect are discarded asynchronously.

## Structure
- Shared package `ex_mem_pkg` contains:
  - typedef `ex_entry_t`, a packed struct with pc, rd, result, data2, tval, cause, load, store.
  - enum `ex_mem_state_e` with RUN, DRAIN, WFI.
  - constant `CAUSE_NONE=5'd0`.
- One sub-module, `skid_buf2`, a generic two-entry ready/valid buffer parameterised on the payload type. The FSM and the redirect logic stay in `ex_mem_stage`.

## Test plan
- Streaming: 8 back-to-back instructions with mem_ready=1 -> mem_pc sequence equals the input sequence, delayed by 1 cycle, with no bubbles.
- Backpressure: mem_ready=0 for 3 cycles while 3 instructions are offered -> 2 are held and ex_ready=0 after the second. The third is accepted after mem_ready=1, and order is preserved.
- Branch: accept pc=0x8000_0010 with bj_en=1, bj_pc=0x8000_0100 -> next cycle redirect_valid=1 and redirect_pc=0x8000_0100 for one cycle. The instruction appears on mem_*.
- Trap: accept cause=2 with trap_vec=0x8000_0400 -> redirect to 0x8000_0400 and ex_ready=0. ex_ready returns to 1 the cycle after trap_done.
- WFI: accept wfi at pc=0x8000_0020, drain the buffer, assert irq_pending -> one redirect pulse to 0x8000_0024, then state RUN.
- Flush: flush with both entries full and a branch redirect pending -> mem_valid=0 and no redirect pulse on the next cycle.
